// File: rtl/jpeg_stream_quantizer_if.sv
// Coefficient stream bundle for the JPEG quantizer.
// The master drives coefficients in and takes results out; the slave is the quantizer.
interface jpeg_stream_quantizer_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 11
);
    logic [1:0]       comp_sel;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_coef;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_coef;
    logic [5:0]       out_idx;
    logic             out_last;
    logic             blk_done;

    modport master (
        output comp_sel, in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_coef, out_idx,
        input  out_last, blk_done
    );

    modport slave (
        input  comp_sel, in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_coef, out_idx,
        output out_last, blk_done
    );
endinterface

// File: rtl/jpeg_stream_quantizer.sv
// Streaming 8x8 DCT quantizer: raster-order coefficients in, rounded
// Annex K quotients out, PIPE cycles later, with a global stall.
module jpeg_stream_quantizer #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 11,
    parameter int PIPE  = 2
) (
    input logic clk,
    input logic rst,
    jpeg_stream_quantizer_if.slave bus
);

    localparam int QMAX = (1 << (OUT_W - 1)) - 1;
    localparam int QMIN = -(1 << (OUT_W - 1));
    localparam int NP   = PIPE - 1;

    localparam int LUMA [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam int CHROMA [64] = '{
        17,  18,  24,  47,  99,  99,  99,  99,
        18,  21,  26,  66,  99,  99,  99,  99,
        24,  26,  56,  99,  99,  99,  99,  99,
        47,  66,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99
    };

    logic             stall;
    logic             in_xfer;
    logic [5:0]       in_idx_q, in_idx_d;
    logic [1:0]       sel_q, sel_d, sel;
    logic [6:0]       t_lut;
    logic             byp;

    logic             s0_v_q;
    logic [IN_W-1:0]  s0_z_q;
    logic [6:0]       s0_t_q;
    logic             s0_byp_q;
    logic [5:0]       s0_idx_q;

    logic             neg;
    logic [IN_W-1:0]  mag;
    logic [IN_W:0]    sum;
    logic [IN_W:0]    quo;
    logic signed [IN_W+1:0] q_full;
    int               q_int;
    logic [OUT_W-1:0] q_d;

    logic             v_q [NP];
    logic [OUT_W-1:0] c_q [NP];
    logic [5:0]       i_q [NP];

    assign stall    = bus.out_valid & ~bus.out_ready;
    assign in_xfer  = bus.in_valid & ~stall;
    assign in_idx_d = in_idx_q + 6'd1;

    // comp_sel only matters on the first coefficient of a block
    assign sel   = (in_idx_q == 6'd0) ? bus.comp_sel : sel_q;
    assign sel_d = in_xfer ? sel : sel_q;

    always_comb begin
        t_lut = 7'd1;
        byp   = 1'b0;
        unique case (sel)
            2'd0: t_lut = 7'(LUMA[in_idx_q]);
            2'd1: t_lut = 7'(CHROMA[in_idx_q]);
            2'd2: t_lut = 7'(CHROMA[in_idx_q]);
            2'd3: byp   = 1'b1;
        endcase
    end

    // magnitude of -2^(IN_W-1) still fits IN_W unsigned bits
    always_comb begin
        neg = s0_z_q[IN_W-1];
        mag = neg ? (~s0_z_q + IN_W'(1)) : s0_z_q;
        sum = {1'b0, mag} + (IN_W+1)'(s0_t_q[6:1]);
        quo = sum / (IN_W+1)'(s0_t_q);
        if (s0_byp_q) begin
            q_full = {{2{s0_z_q[IN_W-1]}}, s0_z_q};
        end else if (neg) begin
            q_full = -$signed({1'b0, quo});
        end else begin
            q_full = $signed({1'b0, quo});
        end
        q_int = int'(q_full);
        if (q_int > QMAX) begin
            q_d = OUT_W'(QMAX);
        end else if (q_int < QMIN) begin
            q_d = OUT_W'(QMIN);
        end else begin
            q_d = OUT_W'(q_int);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_idx_q <= 6'd0;
            sel_q    <= 2'd0;
            s0_v_q   <= 1'b0;
            s0_z_q   <= '0;
            s0_t_q   <= 7'd1;
            s0_byp_q <= 1'b0;
            s0_idx_q <= 6'd0;
            for (int i = 0; i < NP; i++) begin
                v_q[i] <= 1'b0;
                c_q[i] <= '0;
                i_q[i] <= 6'd0;
            end
        end else if (!stall) begin
            if (in_xfer) begin
                in_idx_q <= in_idx_d;
            end
            sel_q    <= sel_d;
            s0_v_q   <= bus.in_valid;
            s0_z_q   <= bus.in_coef;
            s0_t_q   <= t_lut;
            s0_byp_q <= byp;
            s0_idx_q <= in_idx_q;
            v_q[0]   <= s0_v_q;
            c_q[0]   <= q_d;
            i_q[0]   <= s0_idx_q;
            for (int i = 1; i < NP; i++) begin
                v_q[i] <= v_q[i-1];
                c_q[i] <= c_q[i-1];
                i_q[i] <= i_q[i-1];
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v_q[NP-1];
    assign bus.out_coef  = c_q[NP-1];
    assign bus.out_idx   = i_q[NP-1];
    assign bus.out_last  = v_q[NP-1] & (i_q[NP-1] == 6'd63);
    assign bus.blk_done  = bus.out_last & bus.out_ready;

endmodule

// File: tb/tb_jpeg_stream_quantizer.sv
// Randomized bench for jpeg_stream_quantizer with a quotient-level reference model.
// Unit a: OUT_W=11 PIPE=2; unit b: OUT_W=8 PIPE=3 for saturation and latency.
module tb_jpeg_stream_quantizer;

    localparam int PA = 2;
    localparam int PB = 3;

    typedef struct {
        int q;
        int idx;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jpeg_stream_quantizer_if #(.IN_W(11), .OUT_W(11)) a ();
    jpeg_stream_quantizer_if #(.IN_W(11), .OUT_W(8))  b ();

    jpeg_stream_quantizer #(.IN_W(11), .OUT_W(11), .PIPE(PA)) dut_a (
        .clk(clk), .rst(rst), .bus(a)
    );
    jpeg_stream_quantizer #(.IN_W(11), .OUT_W(8), .PIPE(PB)) dut_b (
        .clk(clk), .rst(rst), .bus(b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int hold_cnt = 0;
    bit dropped = 0;
    bit lat_chk = 0;

    exp_t expq [2][$];
    int incnt [2];
    int bsel [2];
    int ocnt [2];
    int dones [2];
    bit was_rst [2];
    int logv [2][256];
    int ow [2] = '{11, 8};
    int lat [2] = '{PA, PB};

    int LUMA_T [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    int CHR4 [16] = '{
        17, 18, 24, 47,
        18, 21, 26, 66,
        24, 26, 56, 99,
        47, 66, 99, 99
    };

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chroma_t(input int idx);
        int r, c;
        r = idx / 8;
        c = idx % 8;
        return (r < 4 && c < 4) ? CHR4[r*4+c] : 99;
    endfunction

    function automatic int model_q(input int z, input int sel,
                                   input int idx, input int w);
        int t, m, q, hi, lo;
        if (sel == 3) begin
            q = z;
        end else begin
            t = (sel == 0) ? LUMA_T[idx] : chroma_t(idx);
            m = (z < 0) ? -z : z;
            q = (m + t / 2) / t;
            if (z < 0) q = -q;
        end
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (q > hi) ? hi : ((q < lo) ? lo : q);
    endfunction

    task automatic mon(input int u, input logic rn,
                       input logic iv, input logic ir,
                       input int sel, input int z,
                       input logic ov, input logic ordy,
                       input int oc, input int oi,
                       input logic ol, input logic bd);
        exp_t e;
        int s;
        string sx;
        sx = (u == 0) ? "_a" : "_b";
        if (!rn) begin
            expq[u].delete();
            incnt[u] = 0;
            was_rst[u] = 1;
            return;
        end
        if (was_rst[u]) begin
            chk({"rst_ovalid", sx}, int'(ov), 0);
            chk({"rst_inready", sx}, int'(ir), 1);
            chk({"rst_coef", sx}, oc, 0);
            chk({"rst_idx", sx}, oi, 0);
            chk({"rst_last", sx}, int'(ol), 0);
            was_rst[u] = 0;
        end
        if (iv && ir) begin
            s = (incnt[u] % 64 == 0) ? sel : bsel[u];
            bsel[u] = s;
            e.idx = incnt[u] % 64;
            e.q = model_q(z, s, e.idx, ow[u]);
            e.cyc = cyc;
            expq[u].push_back(e);
            incnt[u]++;
        end
        if (ov) begin
            if (expq[u].size() == 0) begin
                chk({"spurious_out", sx}, oi, -1);
            end else begin
                e = expq[u][0];
                chk({"coef", sx}, oc, e.q);
                chk({"idx", sx}, oi, e.idx);
                chk({"last", sx}, int'(ol), int'(e.idx == 63));
                if (ordy) begin
                    chk({"blk_done", sx}, int'(bd), int'(e.idx == 63));
                    if (lat_chk) chk({"latency", sx}, cyc - e.cyc, lat[u]);
                    logv[u][ocnt[u] % 256] = oc;
                    ocnt[u]++;
                    if (bd) dones[u]++;
                    void'(expq[u].pop_front());
                end else begin
                    chk({"done_stall", sx}, int'(bd), 0);
                end
            end
        end else begin
            chk({"done_idle", sx}, int'(bd), 0);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon(0, rst, a.in_valid, a.in_ready, int'(a.comp_sel),
            int'($signed(a.in_coef)), a.out_valid, a.out_ready,
            int'($signed(a.out_coef)), int'(a.out_idx),
            a.out_last, a.blk_done);
        mon(1, rst, b.in_valid, b.in_ready, int'(b.comp_sel),
            int'($signed(b.in_coef)), b.out_valid, b.out_ready,
            int'($signed(b.out_coef)), int'(b.out_idx),
            b.out_last, b.blk_done);
    end

    // out_ready pattern for unit a
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                if (hold_cnt > 0) begin
                    a.out_ready = 1'b0;
                    hold_cnt--;
                end else if (!dropped && a.out_valid && a.out_idx == 6'd30) begin
                    dropped = 1;
                    hold_cnt = 4;
                    a.out_ready = 1'b0;
                end else begin
                    a.out_ready = dropped ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
            2: a.out_ready = ($urandom_range(0, 9) < 7);
            3: a.out_ready = 1'b0;
            default: a.out_ready = 1'b1;
        endcase
    end

    task automatic send_a(input int z, input int sel, input int nb);
        bit ok;
        int k;
        ok = 0;
        a.in_valid = 1'b1;
        a.in_coef = 11'(z);
        a.comp_sel = 2'(sel);
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            ok = a.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        chk("accept_a", int'(ok), 1);
        a.in_valid = 1'b0;
        repeat (nb) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_b(input int z, input int sel);
        bit ok;
        int k;
        ok = 0;
        b.in_valid = 1'b1;
        b.in_coef = 11'(z);
        b.comp_sel = 2'(sel);
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            ok = b.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        chk("accept_b", int'(ok), 1);
        b.in_valid = 1'b0;
    endtask

    task automatic drain(input int u);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (expq[u].size() == 0) break;
        end
        chk("drain", expq[u].size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rz();
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int z, s;
        a.in_valid = 1'b0; a.in_coef = '0; a.comp_sel = 2'd0;
        b.in_valid = 1'b0; b.in_coef = '0; b.comp_sel = 2'd0;
        b.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_done_a", int'(a.blk_done), 0);
        @(posedge clk);
        #1;

        // T1 luma
        lat_chk = 1;
        ocnt[0] = 0;
        for (int i = 0; i < 64; i++) begin
            z = (i == 0) ? 200 : (i == 1) ? -8 : (i == 63) ? 50 : 0;
            send_a(z, 0, 0);
        end
        drain(0);
        chk("t1_q0", logv[0][0], 13);
        chk("t1_q1", logv[0][1], -1);
        chk("t1_q63", logv[0][63], 1);
        chk("t1_q5", logv[0][5], 0);

        // T2 chroma, Cb then Cr back to back
        ocnt[0] = 0;
        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                z = (i == 0) ? 50 : (i == 1) ? -9 : (i == 63) ? -1 : 0;
                send_a(z, k, 0);
            end
        end
        drain(0);
        chk("t2_cb_q0", logv[0][0], 3);
        chk("t2_cb_q1", logv[0][1], -1);
        chk("t2_cb_q63", logv[0][63], 0);
        chk("t2_cr_q0", logv[0][64], 3);
        chk("t2_cr_q1", logv[0][65], -1);
        chk("t2_cr_q63", logv[0][127], 0);
        lat_chk = 0;

        // T4 comp_sel change mid-block ignored
        ocnt[0] = 0;
        for (int i = 0; i < 64; i++) send_a(160, (i < 10) ? 0 : 3, 0);
        for (int i = 0; i < 64; i++) send_a(160, 3, 0);
        drain(0);
        chk("t4_luma_q0", logv[0][0], 10);
        chk("t4_byp_q0", logv[0][64], 160);
        chk("t4_byp_q63", logv[0][127], 160);

        // T3 back-pressure over two blocks
        rdy_mode = 1;
        dropped = 0;
        dones[0] = 0;
        ocnt[0] = 0;
        for (int k = 0; k < 2; k++) begin
            s = int'($urandom_range(0, 3));
            for (int i = 0; i < 64; i++) send_a(rz(), s, 0);
        end
        drain(0);
        chk("t3_count", ocnt[0], 128);
        chk("t3_dones", dones[0], 2);
        chk("t3_dropped", int'(dropped), 1);

        // random blocks with bubbles and random ready
        rdy_mode = 2;
        for (int k = 0; k < 3; k++) begin
            s = int'($urandom_range(0, 3));
            for (int i = 0; i < 64; i++) begin
                send_a(rz(), s, int'($urandom_range(0, 2)));
            end
        end
        drain(0);

        // T5 reset mid-block while stalled
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) send_a(rz(), 0, 0);
        rdy_mode = 3;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        rdy_mode = 0;
        ocnt[0] = 0;
        dones[0] = 0;
        for (int i = 0; i < 64; i++) send_a(rz(), 0, 0);
        drain(0);
        chk("t5_count", ocnt[0], 64);
        chk("t5_dones", dones[0], 1);

        // T6 saturation on the narrow unit
        lat_chk = 1;
        ocnt[1] = 0;
        for (int i = 0; i < 64; i++) begin
            z = (i == 0) ? 200 : (i == 1) ? -1024 : rz();
            send_b(z, 3);
        end
        for (int i = 0; i < 64; i++) send_b((i == 0) ? -1024 : rz(), 0);
        drain(1);
        chk("t6_sat_hi", logv[1][0], 127);
        chk("t6_sat_lo", logv[1][1], -128);
        chk("t6_minz_luma", logv[1][64], -64);
        chk("t6_count", ocnt[1], 128);
        lat_chk = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
